shift_register_n: RTL and testbench

Parametrised, multi-cycle universal shift register: the WIDTH-bit successor to the team's 4-bit mode-select shift register.
- Adds a start/busy/done handshake and a multi-bit shift amount, executed one bit position per clock.
- Adds a carry-out flag holding the last bit shifted out.
- Used wherever a datapath needs variable shifts or rotates without a barrel shifter.

---
 rtl/shreg_pkg.sv | 29 ++
 rtl/shreg_step.sv | 49 ++++
 rtl/shift_register_n.sv | 123 ++++++++++++
 tb/tb_shift_register_n.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: operation select
// encoding and FSM state encoding, plus a helper that identifies the
// multi-cycle shift/rotate operations.
package shreg_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD  = 3'b000,
        SEL_LOAD  = 3'b001,
        SEL_LSL   = 3'b010,
        SEL_LSR   = 3'b011,
        SEL_ROL   = 3'b100,
        SEL_ROR   = 3'b101,
        SEL_ASR   = 3'b110,
        SEL_CLEAR = 3'b111
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True for the operations that move bits one position per step.
    function automatic logic is_shift(input sel_e s);
        return (s == SEL_LSL) || (s == SEL_LSR) || (s == SEL_ROL) ||
               (s == SEL_ROR) || (s == SEL_ASR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// Single-bit shift/rotate step. Purely combinational: given the current
// word, the operation and the serial-in bit, produce the word after one
// step and the bit that left the register. Non-shift selects pass the
// word through unchanged with a zero out-bit.
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word_i,
    input  sel_e             sel_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] word_o,
    output logic             out_o
);

    // One-position move; the out-bit is the MSB for left moves and the LSB for right moves.
    always_comb begin
        word_o = word_i;
        out_o  = 1'b0;
        case (sel_i)
            SEL_LSL: begin
                word_o = {word_i[WIDTH-2:0], ser_i};
                out_o  = word_i[WIDTH-1];
            end
            SEL_LSR: begin
                word_o = {ser_i, word_i[WIDTH-1:1]};
                out_o  = word_i[0];
            end
            SEL_ROL: begin
                word_o = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
                out_o  = word_i[WIDTH-1];
            end
            SEL_ROR: begin
                word_o = {word_i[0], word_i[WIDTH-1:1]};
                out_o  = word_i[0];
            end
            SEL_ASR: begin
                word_o = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
                out_o  = word_i[0];
            end
            default: begin
                word_o = word_i;
                out_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_register_n.sv
// WIDTH-bit multi-cycle universal shift register with start/busy/done
// handshake. Handshake: start is sampled only while busy is low; sel, amt
// and d_in are captured on that edge; done pulses for one cycle when the
// result is on d_out, and busy stays high from the start edge until the
// cycle after done. Starts raised while busy are dropped.
// Optional feature: define SHREG_SERIAL_IN_EN to add the sin port, which
// feeds the vacated bit of LSL/LSR; otherwise those shifts insert 0.
module shift_register_n
    import shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d_in,
`ifdef SHREG_SERIAL_IN_EN
    input  logic             sin,
`endif
    output logic [WIDTH-1:0] d_out,
    output logic             shout,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    sel_e             sel_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] d_out_q;
    logic             shout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] step_word_d;
    logic             step_out_d;
    logic             ser_bit;
    sel_e             sel_in;

`ifdef SHREG_SERIAL_IN_EN
    assign ser_bit = sin;
`else
    assign ser_bit = 1'b0;
`endif

    assign sel_in = sel_e'(sel);

    // Steps always use the operation captured at start, never the live sel input.
    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .word_i (d_out_q),
        .sel_i  (sel_q),
        .ser_i  (ser_bit),
        .word_o (step_word_d),
        .out_o  (step_out_d)
    );

    // Control FSM together with the data, count and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_HOLD;
            cnt_q   <= '0;
            d_out_q <= '0;
            shout_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (is_shift(sel_in) && (amt != '0)) begin
                            sel_q   <= sel_in;
                            cnt_q   <= amt;
                            state_q <= ST_RUN;
                        end else begin
                            // Hold and zero-distance shifts leave d_out and shout alone.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            case (sel_in)
                                SEL_LOAD: d_out_q <= d_in;
                                SEL_CLEAR: begin
                                    d_out_q <= '0;
                                    shout_q <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_RUN: begin
                    d_out_q <= step_word_d;
                    shout_q <= step_out_d;
                    cnt_q   <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_out = d_out_q;
    assign shout = shout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Self-checking bench for shift_register_n (WIDTH = 8). Stimulus tasks
// push the predicted result and completion cycle into a scoreboard; a
// monitor pops and compares on every done pulse. The reference model
// computes whole multi-bit shifts with plain shift/rotate arithmetic.
// Builds with or without SHREG_SERIAL_IN_EN.
module tb_shift_register_n;
    import shreg_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;
`ifdef SHREG_SERIAL_IN_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       sel   = '0;
    logic [AMT_W-1:0] amt   = '0;
    logic [WIDTH-1:0] d_in  = '0;
    logic             sin   = 1'b0;
    logic [WIDTH-1:0] d_out;
    logic             shout;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH:0] exp_q[$];
    int             exp_cyc_q[$];

    logic [WIDTH-1:0] m_val = '0;
    logic             m_sh  = 1'b0;

    shift_register_n #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sel   (sel),
        .amt   (amt),
        .d_in  (d_in),
`ifdef SHREG_SERIAL_IN_EN
        .sin   (sin),
`endif
        .d_out (d_out),
        .shout (shout),
        .busy  (busy),
        .done  (done)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-operation reference: result word and final out-bit.
    function automatic logic [WIDTH:0] model(input logic [2:0] s, input int n,
                                             input logic [WIDTH-1:0] din,
                                             input logic [WIDTH-1:0] v,
                                             input logic sh, input logic si);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        logic             o;
        r    = v;
        o    = sh;
        fill = (SER && si) ? '1 : '0;
        case (s)
            3'd0: ;
            3'd1: r = din;
            3'd7: begin r = '0; o = 1'b0; end
            default: begin
                if (n != 0) begin
                    case (s)
                        3'd2: begin r = (v << n) | (fill >> (WIDTH - n)); o = v[WIDTH - n]; end
                        3'd3: begin r = (v >> n) | (fill << (WIDTH - n)); o = v[n - 1]; end
                        3'd4: begin r = (v << n) | (v >> (WIDTH - n)); o = r[0]; end
                        3'd5: begin r = (v >> n) | (v << (WIDTH - n)); o = r[WIDTH - 1]; end
                        3'd6: begin r = $signed(v) >>> n; o = v[n - 1]; end
                        default: ;
                    endcase
                end
            end
        endcase
        return {o, r};
    endfunction

    // Issue one operation once the DUT is idle; returns 1 time unit after the start edge.
    task automatic do_op(input logic [2:0] s, input int n, input logic [WIDTH-1:0] din);
        logic [WIDTH:0] e;
        int             lat;
        int             guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy still %0b after %0d cycles", busy, guard);
        end
        sel   = s;
        amt   = n[AMT_W-1:0];
        d_in  = din;
        sin   = 1'($urandom_range(0, 1));
        start = 1'b1;
        e     = model(s, n, din, m_val, m_sh, sin);
        lat   = (s >= 3'd2 && s <= 3'd6) ? n : 0;
        m_val = e[WIDTH-1:0];
        m_sh  = e[WIDTH];
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + lat);
        sel   = 3'($urandom);
        amt   = AMT_W'($urandom);
        d_in  = WIDTH'($urandom);
    endtask

    // Raise start for one cycle while busy; the DUT must drop it.
    task automatic poke_start();
        @(negedge clk);
        sel   = 3'($urandom);
        amt   = AMT_W'($urandom);
        d_in  = WIDTH'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Assert reset asynchronously and check outputs clear immediately.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_d_out"}, 32'(d_out), 32'h0);
        check({tag, "_shout"}, 32'(shout), 32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_done"},  32'(done),  32'h0);
        exp_q.delete();
        exp_cyc_q.delete();
        m_val = '0;
        m_sh  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no operation outstanding (t=%0t)", $time);
            end else begin
                logic [WIDTH:0] e;
                int             ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("done_d_out", 32'(d_out), 32'(e[WIDTH-1:0]));
                check("done_shout", 32'(shout), 32'(e[WIDTH]));
                check("done_cycle", 32'(cyc), 32'(ec));
                check("done_busy",  32'(busy), 32'h1);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Main sequence
    initial begin
        logic [WIDTH-1:0] rot_exp [3];
        logic [WIDTH-1:0] asr_exp [2];
        int               guard;
        rot_exp[0] = 8'h4B; rot_exp[1] = 8'h96; rot_exp[2] = 8'h2D;
        asr_exp[0] = 8'hCB; asr_exp[1] = 8'hE5;

        #3;
        do_reset("reset_init");
        repeat (2) @(negedge clk);

        // Load A5: result visible after the start edge, busy/done one cycle, shout kept.
        do_op(3'b001, 0, 8'hA5);
        check("load_d_out", 32'(d_out), 32'hA5);
        check("load_busy",  32'(busy),  32'h1);
        check("load_done",  32'(done),  32'h1);
        @(posedge clk);
        #1;
        check("load_done_clear", 32'(done), 32'h0);
        check("load_busy_clear", 32'(busy), 32'h0);

        // ROL by 3 from A5, checking every step.
        do_op(3'b100, 3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rol_step", 32'(d_out), 32'(rot_exp[k]));
        end
        check("rol_shout", 32'(shout), 32'h1);

        // ASR by 2 from 96.
        do_op(3'b001, 0, 8'h96);
        do_op(3'b110, 2, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("asr_step", 32'(d_out), 32'(asr_exp[k]));
        end
        check("asr_shout", 32'(shout), 32'h1);

        // Zero-distance LSR completes in one cycle, data unchanged.
        do_op(3'b011, 0, 8'hFF);
        check("lsr0_d_out", 32'(d_out), 32'hE5);
        check("lsr0_done",  32'(done),  32'h1);

        // Start raised during a 5-step LSL is ignored.
        do_op(3'b001, 0, WIDTH'($urandom));
        do_op(3'b010, 5, 8'h00);
        poke_start();
        poke_start();

        // Clear, then randomized operations with occasional starts while busy.
        do_op(3'b111, 0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), $urandom_range(0, 7), WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0 && busy) poke_start();
        end

        // Reset at step 2 of a 7-step LSR: outputs clear, no done afterwards.
        do_op(3'b001, 0, WIDTH'($urandom));
        do_op(3'b011, 7, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2;
        do_reset("reset_mid_run");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("post_reset_busy", 32'(busy), 32'h0);
            check("post_reset_done", 32'(done), 32'h0);
        end

        // A few more random operations after reset.
        for (int i = 0; i < 10; i++) begin
            do_op(3'($urandom_range(0, 7)), $urandom_range(0, 7), WIDTH'($urandom));
        end

        // Drain the scoreboard.
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
